rotary_addr_bank: RTL and testbench

- Parametrised multi-channel address selector driven by a quadrature rotary encoder and its push button.
- Keeps CHANNELS independent address registers. The channel chosen by `sel` is stepped up or down by full encoder detents and cleared by the centre press.
- Feeds debug/display address ports in the CPU clock domain.
- Replaces the ad-hoc edge-compare rotary logic of the top level. Adds full Gray-code decoding, bounce rejection, wrap/saturate mode and a clear function.

---
 rtl/rotary_addr_bank_pkg.sv | 30 +++
 rtl/rotary_addr_bank_quad_decoder.sv | 69 ++++++
 rtl/rotary_addr_bank.sv | 136 +++++++++++++
 tb/tb_rotary_addr_bank.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/rotary_addr_bank_pkg.sv
// Shared encodings for the rotary address bank: quadrature states, step
// directions and the detent accumulator limits.
package rotary_addr_bank_pkg;

    typedef enum logic [1:0] {
        QS_00 = 2'b00,
        QS_01 = 2'b01,
        QS_11 = 2'b11,
        QS_10 = 2'b10
    } qstate_t;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    // One extra bit beyond three so that a full detent (+4) is representable.
    localparam int ACC_W = 4;
    localparam logic signed [ACC_W-1:0] ACC_MAX = 4'sd4;
    localparam logic signed [ACC_W-1:0] ACC_MIN = -4'sd4;

    // Single-bit transitions along 00->01->11->10->00 count as "up".
    function automatic logic is_up_move(input qstate_t from_s, input qstate_t to_s);
        case (from_s)
            QS_00:   return to_s == QS_01;
            QS_01:   return to_s == QS_11;
            QS_11:   return to_s == QS_10;
            default: return to_s == QS_00;
        endcase
    endfunction

endpackage

// File: rtl/rotary_addr_bank_quad_decoder.sv
// Synchronises the encoder pins and decodes full Gray-code detents into
// one-cycle up/down/error strobes plus a push-button rising-edge strobe.
module quad_decoder
    import rotary_addr_bank_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic rot_a_i,
    input  logic rot_b_i,
    input  logic rot_ctr_i,
    output logic step_up_o,
    output logic step_dn_o,
    output logic err_o,
    output logic ctr_rise_o
);

    logic [1:0] a_sync_q;
    logic [1:0] b_sync_q;
    logic [2:0] ctr_sync_q;
    qstate_t    state_q, state_d;
    qstate_t    cur_s;
    logic signed [ACC_W-1:0] acc_q, acc_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sync_q   <= '0;
            b_sync_q   <= '0;
            ctr_sync_q <= '0;
            state_q    <= QS_00;
            acc_q      <= '0;
        end else begin
            a_sync_q   <= {a_sync_q[0], rot_a_i};
            b_sync_q   <= {b_sync_q[0], rot_b_i};
            ctr_sync_q <= {ctr_sync_q[1:0], rot_ctr_i};
            state_q    <= state_d;
            acc_q      <= acc_d;
        end
    end

    assign cur_s      = qstate_t'({a_sync_q[1], b_sync_q[1]});
    assign ctr_rise_o = ctr_sync_q[1] & ~ctr_sync_q[2];

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        step_up_o = 1'b0;
        step_dn_o = 1'b0;
        err_o     = 1'b0;
        if (cur_s != state_q) begin
            state_d = cur_s;
            if ((cur_s ^ state_q) == 2'b11) begin
                err_o = 1'b1;
                acc_d = '0;
            end else begin
                if (is_up_move(state_q, cur_s))
                    acc_d = (acc_q == ACC_MAX) ? acc_q : acc_q + 4'sd1;
                else
                    acc_d = (acc_q == ACC_MIN) ? acc_q : acc_q - 4'sd1;
                // Only a complete detent survives the return to rest.
                if (cur_s == QS_00) begin
                    step_up_o = (acc_d == ACC_MAX);
                    step_dn_o = (acc_d == ACC_MIN);
                    acc_d     = '0;
                end
            end
        end
    end

endmodule

// File: rtl/rotary_addr_bank.sv
// Multi-channel address bank stepped by a rotary encoder and cleared by its
// push button. Define ROT_ACCEL_EN to enable step acceleration.
module rotary_addr_bank
    import rotary_addr_bank_pkg::*;
#(
    parameter int CHANNELS     = 4,
    parameter int SEL_W        = 2,
    parameter int ADDR_W       = 5,
    parameter int WRAP         = 1,
    parameter int ACCEL_CYCLES = 500000,
    parameter int ACCEL_STEP   = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [SEL_W-1:0]           sel,
    input  logic                       rot_a,
    input  logic                       rot_b,
    input  logic                       rot_ctr,
    output logic [ADDR_W-1:0]          addr_o,
    output logic [CHANNELS*ADDR_W-1:0] addr_all,
    output logic                       step_pulse,
    output logic                       step_dir,
    output logic                       err_pulse
);

    localparam logic [31:0] ADDR_MAX = (32'd1 << ADDR_W) - 32'd1;

    if (CHANNELS < 2 || CHANNELS > 16 || (1 << SEL_W) < CHANNELS ||
        ADDR_W < 1 || ADDR_W > 16 || ACCEL_STEP < 1 || ACCEL_CYCLES < 1) begin : g_bad_params
        $error("rotary_addr_bank: illegal parameter set");
    end

    logic step_up, step_dn, dec_err, ctr_rise;
    logic sel_ok, clear, commit;
    logic [31:0] mag;
    logic [31:0] base_w, sum_w;
    logic [ADDR_W-1:0] diff_w, step_val;
    logic step_pulse_q, step_dir_q, err_q;

    quad_decoder u_dec (
        .clk        (clk),
        .rst_n      (rst_n),
        .rot_a_i    (rot_a),
        .rot_b_i    (rot_b),
        .rot_ctr_i  (rot_ctr),
        .step_up_o  (step_up),
        .step_dn_o  (step_dn),
        .err_o      (dec_err),
        .ctr_rise_o (ctr_rise)
    );

    assign sel_ok = (32'(sel) < 32'(CHANNELS));
    assign clear  = ctr_rise & sel_ok;
    assign commit = (step_up | step_dn) & sel_ok & ~clear;

`ifdef ROT_ACCEL_EN
    logic [31:0] cnt_q, cnt_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= 32'(ACCEL_CYCLES);
        else        cnt_q <= cnt_d;
    end

    always_comb begin
        mag   = (cnt_q < 32'(ACCEL_CYCLES)) ? 32'(ACCEL_STEP) : 32'd1;
        cnt_d = cnt_q;
        if (commit)
            cnt_d = '0;
        else if (cnt_q < 32'(ACCEL_CYCLES))
            cnt_d = cnt_q + 32'd1;
    end
`else
    assign mag = 32'd1;
`endif

    // The selected channel's current value is addr_o, so one adder serves all.
    always_comb begin
        base_w   = 32'(addr_o);
        sum_w    = base_w + mag;
        diff_w   = addr_o - mag[ADDR_W-1:0];
        step_val = addr_o;
        if (WRAP != 0)
            step_val = step_up ? sum_w[ADDR_W-1:0] : diff_w;
        else if (step_up)
            step_val = (sum_w > ADDR_MAX) ? ADDR_MAX[ADDR_W-1:0] : sum_w[ADDR_W-1:0];
        else
            step_val = (base_w < mag) ? '0 : diff_w;
    end

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
        logic hit;
        logic [ADDR_W-1:0] ch_q, ch_d;

        assign hit = sel_ok && (32'(sel) == 32'(gi));

        always_comb begin
            ch_d = ch_q;
            if (hit && clear)
                ch_d = '0;
            else if (hit && commit)
                ch_d = step_val;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) ch_q <= '0;
            else        ch_q <= ch_d;
        end

        assign addr_all[gi*ADDR_W +: ADDR_W] = ch_q;
    end

    always_comb begin
        addr_o = '0;
        for (int i = 0; i < CHANNELS; i++)
            if (sel_ok && 32'(sel) == 32'(i))
                addr_o = addr_all[i*ADDR_W +: ADDR_W];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            step_pulse_q <= 1'b0;
            step_dir_q   <= DIR_DOWN;
            err_q        <= 1'b0;
        end else begin
            step_pulse_q <= commit;
            err_q        <= dec_err;
            if (commit)
                step_dir_q <= step_up ? DIR_UP : DIR_DOWN;
        end
    end

    assign step_pulse = step_pulse_q;
    assign step_dir   = step_dir_q;
    assign err_pulse  = err_q;

endmodule

// File: tb/tb_rotary_addr_bank.sv
// Directed and randomised stimulus for rotary_addr_bank, checked against a
// transaction-level model of detents, wrap/saturate, clear and acceleration.
module tb_rotary_addr_bank;

    localparam int CH = 4;
    localparam int SW = 3;
    localparam int AW = 5;
    localparam int AC = 100;
    localparam int AS = 4;
    localparam int MAXV = (1 << AW) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic [SW-1:0] sel;
    logic rot_a, rot_b, rot_ctr;
    logic [AW-1:0] addr_o_w, addr_o_s;
    logic [CH*AW-1:0] all_w, all_s;
    logic sp_w, sd_w, ep_w, sp_s, sd_s, ep_s;

    rotary_addr_bank #(.CHANNELS(CH), .SEL_W(SW), .ADDR_W(AW), .WRAP(1),
                       .ACCEL_CYCLES(AC), .ACCEL_STEP(AS)) u_wrap (
        .clk(clk), .rst_n(rst_n), .sel(sel), .rot_a(rot_a), .rot_b(rot_b),
        .rot_ctr(rot_ctr), .addr_o(addr_o_w), .addr_all(all_w),
        .step_pulse(sp_w), .step_dir(sd_w), .err_pulse(ep_w));

    rotary_addr_bank #(.CHANNELS(CH), .SEL_W(SW), .ADDR_W(AW), .WRAP(0),
                       .ACCEL_CYCLES(AC), .ACCEL_STEP(AS)) u_sat (
        .clk(clk), .rst_n(rst_n), .sel(sel), .rot_a(rot_a), .rot_b(rot_b),
        .rot_ctr(rot_ctr), .addr_o(addr_o_s), .addr_all(all_s),
        .step_pulse(sp_s), .step_dir(sd_s), .err_pulse(ep_s));

    always #5 clk = ~clk;

    int cyc = 0;
    int n_step = 0, n_step_s = 0, n_err = 0;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) begin
        if (sp_w) n_step   <= n_step + 1;
        if (sp_s) n_step_s <= n_step_s + 1;
        if (ep_w) n_err    <= n_err + 1;
    end

    int compared = 0;
    int mismatched = 0;

    // Reference model state
    int m_w[CH];
    int m_s[CH];
    int m_acc = 0;
    logic [1:0] m_ab = 2'b00;
    logic m_ctr = 1'b0;
    int m_last = -1;
    int m_dir = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int gpos(input logic [1:0] ab);
        case (ab)
            2'b00:   return 0;
            2'b01:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    function automatic logic [1:0] gab(input int p);
        logic [1:0] t [4];
        t[0] = 2'b00; t[1] = 2'b01; t[2] = 2'b11; t[3] = 2'b10;
        return t[p & 3];
    endfunction

    function automatic logic [CH*AW-1:0] pack(input int v[CH]);
        logic [CH*AW-1:0] r;
        r = '0;
        for (int i = 0; i < CH; i++) r[i*AW +: AW] = AW'(v[i]);
        return r;
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Apply one pin change (called #1 after a rising edge) and check the result.
    task automatic move(input logic [1:0] ab, input logic ctr, input string tag, input bit lat);
        int k, d, cdir, mag, s0, ss0, e0, exp_err, exp_step;
        bit valid, clr;
        logic [CH*AW-1:0] old_w;
        old_w = pack(m_w);
        s0 = n_step; ss0 = n_step_s; e0 = n_err;
        k = cyc;
        {rot_a, rot_b} = ab;
        rot_ctr = ctr;

        cdir = -1; exp_err = 0; exp_step = 0;
        d = (gpos(ab) - gpos(m_ab) + 4) % 4;
        if (d == 2) begin
            exp_err = 1; m_acc = 0;
        end else if (d == 1) begin
            m_acc = (m_acc < 4) ? m_acc + 1 : 4;
        end else if (d == 3) begin
            m_acc = (m_acc > -4) ? m_acc - 1 : -4;
        end
        if ((d == 1 || d == 3) && ab == 2'b00) begin
            if (m_acc == 4) cdir = 1;
            else if (m_acc == -4) cdir = 0;
            m_acc = 0;
        end
        m_ab = ab;
        valid = (int'(sel) < CH);
        clr = ctr && !m_ctr && valid;
        m_ctr = ctr;
        if (clr) begin
            m_w[sel] = 0; m_s[sel] = 0;
        end else if (cdir >= 0 && valid) begin
            mag = 1;
`ifdef ROT_ACCEL_EN
            if (m_last >= 0 && (k - m_last - 1) < AC) mag = AS;
`endif
            m_last = k;
            m_dir = cdir;
            exp_step = 1;
            if (cdir == 1) begin
                m_w[sel] = (m_w[sel] + mag) % (MAXV + 1);
                m_s[sel] = (m_s[sel] + mag > MAXV) ? MAXV : m_s[sel] + mag;
            end else begin
                m_w[sel] = (m_w[sel] - mag + 4 * (MAXV + 1)) % (MAXV + 1);
                m_s[sel] = (m_s[sel] - mag < 0) ? 0 : m_s[sel] - mag;
            end
        end

        if (lat) begin
            repeat (2) @(posedge clk);
            #1;
            chk({tag, "_lat2"}, all_w, old_w);
            @(posedge clk);
            #1;
            chk({tag, "_lat3"}, all_w, pack(m_w));
            chk({tag, "_lat3_pulse"}, sp_w, exp_step);
            repeat (3) @(posedge clk);
            #1;
        end else begin
            repeat (6) @(posedge clk);
            #1;
        end

        chk({tag, "_all_wrap"}, all_w, pack(m_w));
        chk({tag, "_all_sat"}, all_s, pack(m_s));
        chk({tag, "_addr_o"}, addr_o_w, valid ? m_w[sel] : 0);
        chk({tag, "_steps"}, n_step - s0, exp_step);
        chk({tag, "_steps_sat"}, n_step_s - ss0, exp_step);
        chk({tag, "_errs"}, n_err - e0, exp_err);
        chk({tag, "_dir"}, sd_w, m_dir);
        $display("move %-12s ab=%b ctr=%b sel=%0d step=%0d err=%0d addr_all=%h",
                 tag, ab, ctr, sel, exp_step, exp_err, all_w);
    endtask

    task automatic rot_up(input string tag);
        move(2'b01, m_ctr, tag, 0);
        move(2'b11, m_ctr, tag, 0);
        move(2'b10, m_ctr, tag, 0);
        move(2'b00, m_ctr, tag, 0);
    endtask

    initial begin
        int p, r, dirp;
        logic c;
        for (int i = 0; i < CH; i++) begin m_w[i] = 0; m_s[i] = 0; end
        rst_n = 1'b0; sel = '0; rot_a = 0; rot_b = 0; rot_ctr = 0;
        #12;
        chk("rst_all", all_w, 0);
        chk("rst_pulse", sp_w, 0);
        chk("rst_dir", sd_w, 0);
        chk("rst_err", ep_w, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle(3);

        // One up detent on ch1, with exact pin-to-register latency check
        sel = 3'd1;
        move(2'b01, 0, "up1", 0);
        move(2'b11, 0, "up1", 0);
        move(2'b10, 0, "up1", 0);
        move(2'b00, 0, "up1", 1);
        chk("up1_ch1", all_w[1*AW +: AW], 1);

        // Down from 0 on ch0: wraps in one instance, clamps in the other
        sel = 3'd0;
        move(2'b10, 0, "dn0", 0);
        move(2'b11, 0, "dn0", 0);
        move(2'b01, 0, "dn0", 0);
        move(2'b00, 0, "dn0", 0);
        chk("dn0_sat_ch0", all_s[0 +: AW], 0);

        // Partial turn, then an illegal jump
        move(2'b10, 0, "partial", 0);
        move(2'b11, 0, "partial", 0);
        move(2'b10, 0, "partial", 0);
        move(2'b00, 0, "partial", 0);
        move(2'b11, 0, "jump", 0);
        move(2'b10, 0, "recover", 0);
        move(2'b00, 0, "recover", 0);

        // Clear colliding with a committed step on ch2
        sel = 3'd2;
        for (int i = 0; i < 7; i++) rot_up("ch2up");
        move(2'b01, 0, "clrhit", 0);
        move(2'b11, 0, "clrhit", 0);
        move(2'b10, 0, "clrhit", 0);
        move(2'b00, 1, "clrhit", 0);
        chk("clrhit_ch2", all_w[2*AW +: AW], 0);
        move(2'b00, 0, "release", 0);

        // sel changes mid-rotation: only ch3 moves
        sel = 3'd0;
        move(2'b10, 0, "selsw", 0);
        move(2'b11, 0, "selsw", 0);
        sel = 3'd3;
        move(2'b01, 0, "selsw", 0);
        move(2'b00, 0, "selsw", 0);

        // Out-of-range select: no step, no clear, addr_o reads 0
        sel = 3'd5;
        rot_up("sel5");
        move(2'b00, 1, "sel5clr", 0);
        move(2'b00, 0, "sel5rel", 0);
        chk("sel5_addr_o", addr_o_w, 0);

        // Acceleration spacing on ch1 cleared to 0
        sel = 3'd1;
        move(2'b00, 1, "acc_clr", 0);
        move(2'b00, 0, "acc_rel", 0);
        idle(200);
        rot_up("acc1");
        chk("acc1_ch1", all_w[1*AW +: AW], 1);
        idle(26);
        rot_up("acc2");
`ifdef ROT_ACCEL_EN
        chk("acc2_ch1", all_w[1*AW +: AW], 5);
`else
        chk("acc2_ch1", all_w[1*AW +: AW], 2);
`endif
        idle(200);
        rot_up("acc3");
`ifdef ROT_ACCEL_EN
        chk("acc3_ch1", all_w[1*AW +: AW], 6);
`else
        chk("acc3_ch1", all_w[1*AW +: AW], 3);
`endif

        // Randomised walk
        dirp = 1;
        for (int n = 0; n < 250; n++) begin
            r = $urandom_range(0, 99);
            if ($urandom_range(0, 9) == 0) sel = SW'($urandom_range(0, 7));
            if ($urandom_range(0, 4) == 0) dirp = -dirp;
            p = gpos(m_ab);
            c = ($urandom_range(0, 7) == 0) ? ~m_ctr : m_ctr;
            if (r < 75)      move(gab(p + dirp + 4), c, "rnd_step", 0);
            else if (r < 82) move(gab(p + 2), c, "rnd_ill", 0);
            else             move(m_ab, ~m_ctr, "rnd_btn", 0);
            if ($urandom_range(0, 19) == 0) idle($urandom_range(0, 150));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
